// File: rtl/fetch_pc_unit_pkg.sv
// Shared defaults and the per-cycle fetch-control encoding for the PC/fetch stage.
package fetch_pc_unit_pkg;

   localparam int unsigned DEF_ADDR_W   = 32;
   localparam int unsigned DEF_DATA_W   = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0;
   localparam int unsigned DEF_PC_STEP  = 1;

   typedef enum logic [1:0] {
      FETCH_NORMAL   = 2'd0,
      FETCH_STALL    = 2'd1,
      FETCH_REDIRECT = 2'd2,
      FETCH_HALT     = 2'd3
   } fetch_ctrl_e;

endpackage

// File: rtl/fetch_next_pc_mux.sv
// Combinational selection of the BRAM address and the next pc_q value.
module fetch_next_pc_mux
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned PC_STEP = DEF_PC_STEP
) (
   input  fetch_ctrl_e       i_ctrl,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_out_pc,
   input  logic              i_out_valid,
   input  logic [ADDR_W-1:0] i_redirect_pc,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [ADDR_W-1:0] o_next_pc
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   always_comb begin
      o_imem_addr = i_pc;
      o_next_pc   = i_pc;
      case (i_ctrl)
         FETCH_NORMAL: begin
            o_imem_addr = i_pc;
            o_next_pc   = i_pc + STEP;
         end
         FETCH_STALL: begin
            // Before the first word is out, re-reading out_pc would lose RESET_PC.
            o_imem_addr = i_out_valid ? i_out_pc : i_pc;
            o_next_pc   = i_pc;
         end
         FETCH_REDIRECT: begin
            o_imem_addr = i_redirect_pc;
            o_next_pc   = i_redirect_pc + STEP;
         end
         FETCH_HALT: begin
            o_imem_addr = i_out_pc;
            o_next_pc   = i_pc;
         end
      endcase
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// PC and fetch sequencing ahead of a 1-cycle-latency instruction BRAM; pairs
// each returned word with its PC and a valid flag.
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W   = DEF_ADDR_W,
   parameter int unsigned       DATA_W   = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
   parameter int unsigned       PC_STEP  = DEF_PC_STEP
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic [ADDR_W-1:0] pc_plus_step,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_out_pc;
   logic              r_out_valid;
   logic              r_halted;

   fetch_ctrl_e       w_ctrl;
   logic [ADDR_W-1:0] w_next_pc;

   always_comb begin
      w_ctrl = FETCH_NORMAL;
      if (r_halted || halt)   w_ctrl = FETCH_HALT;
      else if (redirect_valid) w_ctrl = FETCH_REDIRECT;
      else if (stall)          w_ctrl = FETCH_STALL;
   end

   fetch_next_pc_mux #(
      .ADDR_W  (ADDR_W),
      .PC_STEP (PC_STEP)
   ) u_mux (
      .i_ctrl        (w_ctrl),
      .i_pc          (r_pc),
      .i_out_pc      (r_out_pc),
      .i_out_valid   (r_out_valid),
      .i_redirect_pc (redirect_pc),
      .o_imem_addr   (imem_addr),
      .o_next_pc     (w_next_pc)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pc        <= RESET_PC;
         r_out_pc    <= '0;
         r_out_valid <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         case (w_ctrl)
            FETCH_NORMAL: begin
               r_out_pc    <= r_pc;
               r_out_valid <= 1'b1;
               r_pc        <= w_next_pc;
            end
            FETCH_REDIRECT: begin
               r_out_pc    <= redirect_pc;
               r_out_valid <= 1'b1;
               r_pc        <= w_next_pc;
            end
            FETCH_HALT: begin
               r_halted    <= 1'b1;
               r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign instr_valid  = r_out_valid;
   assign instr        = r_out_valid ? imem_rdata : '0;
   assign instr_pc     = r_out_pc;
   assign pc_plus_step = r_out_pc + STEP;
   assign halted       = r_halted;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a behavioural 1-cycle BRAM.
module tb_fetch_pc_unit;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus_step;
   logic        halted;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [31:0] rpc;
      logic        halt;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_pps;
      logic        e_halted;
   } vec_t;

   vec_t vq[$];

   fetch_pc_unit #(
      .ADDR_W   (32),
      .DATA_W   (32),
      .RESET_PC (32'h0),
      .PC_STEP  (1)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .pc_plus_step   (pc_plus_step),
      .halted         (halted)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   always @(posedge clock) imem_rdata <= word_at(imem_addr);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] ea, input logic ev,
                          input logic [31:0] ep, input logic [31:0] epps, input logic eh);
      chk({tag, " imem_addr"}, imem_addr, ea);
      chk({tag, " instr_valid"}, 32'(instr_valid), 32'(ev));
      chk({tag, " instr_pc"}, instr_pc, ep);
      chk({tag, " pc_plus_step"}, pc_plus_step, epps);
      chk({tag, " halted"}, 32'(halted), 32'(eh));
      chk({tag, " instr"}, instr, ev ? word_at(ep) : 32'h0);
   endtask

   task automatic drive(input logic s, input logic rv, input logic [31:0] rpc, input logic h);
      stall = s;
      redirect_valid = rv;
      redirect_pc = rpc;
      halt = h;
   endtask

   initial begin
      //                s  rv rpc            h  addr           v  pc             pps            hlt
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 32'h0,      32'h1,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h1,      1'b1, 32'h0,      32'h1,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h2,      1'b1, 32'h1,      32'h2,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h3,      1'b1, 32'h2,      32'h3,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h4,      1'b1, 32'h3,      32'h4,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h5,      1'b1, 32'h4,      32'h5,      1'b0});
      vq.push_back('{1'b1, 1'b0, 32'h0,      1'b0, 32'h5,      1'b1, 32'h5,      32'h6,      1'b0});
      vq.push_back('{1'b1, 1'b0, 32'h0,      1'b0, 32'h5,      1'b1, 32'h5,      32'h6,      1'b0});
      vq.push_back('{1'b1, 1'b0, 32'h0,      1'b0, 32'h5,      1'b1, 32'h5,      32'h6,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h6,      1'b1, 32'h5,      32'h6,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h7,      1'b1, 32'h6,      32'h7,      1'b0});
      vq.push_back('{1'b0, 1'b1, 32'h40,     1'b0, 32'h40,     1'b1, 32'h7,      32'h8,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h41,     1'b1, 32'h40,     32'h41,     1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h42,     1'b1, 32'h41,     32'h42,     1'b0});
      vq.push_back('{1'b1, 1'b1, 32'h80,     1'b0, 32'h80,     1'b1, 32'h42,     32'h43,     1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h81,     1'b1, 32'h80,     32'h81,     1'b0});
      vq.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h81,   32'h82,     1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h0,      1'b1, 32'hFFFFFFFF, 32'h0,    1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'h1,      1'b1, 32'h0,      32'h1,      1'b0});
      vq.push_back('{1'b0, 1'b1, 32'h9,      1'b0, 32'h9,      1'b1, 32'h1,      32'h2,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'hA,      1'b1, 32'h9,      32'hA,      1'b0});
      vq.push_back('{1'b0, 1'b1, 32'h55,     1'b1, 32'hA,      1'b1, 32'hA,      32'hB,      1'b0});
      vq.push_back('{1'b0, 1'b0, 32'h0,      1'b0, 32'hA,      1'b0, 32'hA,      32'hB,      1'b1});

      repeat (2) @(negedge clock);
      #1 chk_all("in_reset", 32'h0, 1'b0, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         if (i > 0) @(negedge clock);
         drive(vq[i].stall, vq[i].rv, vq[i].rpc, vq[i].halt);
         #1 chk_all($sformatf("vec%0d", i), vq[i].e_addr, vq[i].e_valid, vq[i].e_pc,
                    vq[i].e_pps, vq[i].e_halted);
      end

      // Halted state must ignore everything.
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
         #1 chk_all($sformatf("halted%0d", i), 32'hA, 1'b0, 32'hA, 32'hB, 1'b1);
      end

      // Reset pulse restarts at RESET_PC, with a stall in the first cycle.
      @(negedge clock);
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      reset_n = 1'b0;
      #1 chk_all("rst_pulse", 32'h0, 1'b0, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      stall = 1'b1;
      #1 chk_all("first_stall", 32'h0, 1'b0, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      stall = 1'b0;
      #1 chk_all("post_stall0", 32'h0, 1'b0, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      #1 chk_all("post_stall1", 32'h1, 1'b1, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      #1 chk_all("post_stall2", 32'h2, 1'b1, 32'h1, 32'h2, 1'b0);
      @(negedge clock);
      stall = 1'b1;
      #1 chk_all("stall_pre_rst", 32'h2, 1'b1, 32'h2, 32'h3, 1'b0);

      // Asynchronous reset away from any clock edge.
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1 chk_all("async_rst", 32'h0, 1'b0, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      stall = 1'b0;
      #1 chk_all("resume0", 32'h0, 1'b0, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      #1 chk_all("resume1", 32'h1, 1'b1, 32'h0, 32'h1, 1'b0);
      @(negedge clock);
      #1 chk_all("resume2", 32'h2, 1'b1, 32'h1, 32'h2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
